// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: four-ghost CHASE/FRIGHTEN/DEAD controller with a shared
// frighten timer, eat-chain scoring, per-ghost dead timers and player death.
// Ports: clock, reset (sync, active high), tick (frame strobe), pellet_eaten,
//   player_x/y, packed ghost_x/y (slice i = ghost i) -> ghost_mode (2b/ghost),
//   frighten_flash, ghost_eaten (pulse), score_add (pulse cycle), game_over.
`ifndef WIDTH
`define WIDTH 320
`endif
`ifndef HEIGHT
`define HEIGHT 240
`endif

module ghost_mode_ctrl #(
  parameter int FRIGHTEN_TICKS = 360,
  parameter int FLASH_TICKS    = 120,
  parameter int DEAD_TICKS     = 180,
  parameter int HIT_RADIUS     = 8,
  localparam int XW = $clog2(`WIDTH),
  localparam int YW = $clog2(`HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic          pellet_eaten,
  input  logic [XW-1:0] player_x,
  input  logic [YW-1:0] player_y,
  input  logic [4*XW-1:0] ghost_x,
  input  logic [4*YW-1:0] ghost_y,
  output logic [7:0]    ghost_mode,
  output logic          frighten_flash,
  output logic [3:0]    ghost_eaten,
  output logic [11:0]   score_add,
  output logic          game_over
);

  localparam int FW = $clog2(FRIGHTEN_TICKS + 1);
  localparam int DW = $clog2(DEAD_TICKS + 1);

  typedef enum logic [1:0] {
    CHASE  = 2'b00,
    FRIGHT = 2'b01,
    DEAD   = 2'b10
  } gmode_t;

  gmode_t        r_mode [4];
  logic [DW-1:0] r_dead [4];
  logic [FW-1:0] r_fr;
  logic [1:0]    r_chain;
  logic          r_pend;
  logic          r_go;
  logic [3:0]    r_eaten;
  logic [11:0]   r_score;

  gmode_t        w_m1     [4];
  gmode_t        w_mode_n [4];
  logic [DW-1:0] w_dead_n [4];
  logic [XW-1:0] w_dx     [4];
  logic [YW-1:0] w_dy     [4];
  logic [3:0]    w_hit;
  logic [3:0]    w_eat;
  logic          w_pel;
  logic          w_die;
  logic          w_expire;
  logic [FW-1:0] w_fr1;
  logic [FW-1:0] w_fr_n;
  logic [1:0]    w_pos;
  logic [11:0]   w_score;
  logic [DW-1:0] w_d;

  // Unsigned distance per axis, computed by larger-minus-smaller.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [XW-1:0] gx;
      logic [YW-1:0] gy;
      gx = ghost_x[i*XW +: XW];
      gy = ghost_y[i*YW +: YW];
      w_dx[i] = (player_x >= gx) ? player_x - gx : gx - player_x;
      w_dy[i] = (player_y >= gy) ? player_y - gy : gy - player_y;
      w_hit[i] = (w_dx[i] < XW'(HIT_RADIUS)) &&
                 (w_dy[i] < YW'(HIT_RADIUS));
    end
  end

  always_comb begin
    w_pel    = r_pend | pellet_eaten;
    w_fr1    = w_pel ? FW'(FRIGHTEN_TICKS) : r_fr;
    w_pos    = w_pel ? 2'd0 : r_chain;
    w_die    = 1'b0;
    w_eat    = '0;
    w_score  = '0;
    w_d      = '0;
    w_expire = (w_fr1 == FW'(1));
    w_fr_n   = (w_fr1 != '0) ? w_fr1 - FW'(1) : '0;
    for (int i = 0; i < 4; i++) begin
      w_m1[i]     = (w_pel && r_mode[i] != DEAD) ? FRIGHT : r_mode[i];
      w_mode_n[i] = w_m1[i];
      w_dead_n[i] = r_dead[i];
      if (w_hit[i] && w_m1[i] == CHASE) w_die = 1'b1;
    end
    // Ascending index order sets each eaten ghost's chain position.
    for (int i = 0; i < 4; i++) begin
      if (w_hit[i] && w_m1[i] == FRIGHT) begin
        w_eat[i]    = 1'b1;
        w_score     = w_score + (12'd200 << w_pos);
        w_pos       = (w_pos == 2'd3) ? 2'd3 : w_pos + 2'd1;
        w_mode_n[i] = DEAD;
        w_dead_n[i] = DW'(DEAD_TICKS);
      end
    end
    // Dead timers send ghosts to CHASE only, regardless of frighten state.
    for (int i = 0; i < 4; i++) begin
      if (w_mode_n[i] == DEAD) begin
        w_d = (w_dead_n[i] != '0) ? w_dead_n[i] - DW'(1) : '0;
        w_dead_n[i] = w_d;
        if (w_d == '0) w_mode_n[i] = CHASE;
      end else if (w_mode_n[i] == FRIGHT && w_expire) begin
        w_mode_n[i] = CHASE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fr    <= '0;
      r_chain <= '0;
      r_pend  <= 1'b0;
      r_go    <= 1'b0;
      r_eaten <= '0;
      r_score <= '0;
      for (int i = 0; i < 4; i++) begin
        r_mode[i] <= CHASE;
        r_dead[i] <= '0;
      end
    end else begin
      r_eaten <= '0;
      r_score <= '0;
      if (!r_go) begin
        if (tick) begin
          if (w_die) begin
            r_go <= 1'b1;
          end else begin
            r_pend  <= 1'b0;
            r_fr    <= w_fr_n;
            r_chain <= w_pos;
            r_eaten <= w_eat;
            r_score <= w_score;
            for (int i = 0; i < 4; i++) begin
              r_mode[i] <= w_mode_n[i];
              r_dead[i] <= w_dead_n[i];
            end
          end
        end else if (pellet_eaten) begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign ghost_mode[2*g +: 2] = r_mode[g];
  end

  assign frighten_flash = (r_fr != '0) && (r_fr <= FW'(FLASH_TICKS));
  assign ghost_eaten    = r_eaten;
  assign score_add      = r_score;
  assign game_over      = r_go;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// tb_ghost_mode_ctrl: directed vectors with a scoreboard queue; a monitor
// pops one expectation per checked cycle and compares all outputs.
`ifndef WIDTH
`define WIDTH 320
`endif
`ifndef HEIGHT
`define HEIGHT 240
`endif

module tb_ghost_mode_ctrl;

  localparam int XW = $clog2(`WIDTH);
  localparam int YW = $clog2(`HEIGHT);

  typedef struct {
    string       nm;
    logic [7:0]  mode;
    logic        fl;
    logic [3:0]  eat;
    logic [11:0] sc;
    logic        go;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          pel = 1'b0;
  logic [XW-1:0] px = XW'(100);
  logic [YW-1:0] py = YW'(100);
  logic [XW-1:0] gx [4];
  logic [YW-1:0] gy [4];
  logic [4*XW-1:0] gxp;
  logic [4*YW-1:0] gyp;
  logic [7:0]    mode;
  logic          flash;
  logic [3:0]    eaten;
  logic [11:0]   score;
  logic          go;

  exp_t sbq [$];
  exp_t cur;
  logic chk_req = 1'b0;
  logic chk_d = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  always_comb begin
    gxp = '0;
    gyp = '0;
    for (int i = 0; i < 4; i++) begin
      gxp[i*XW +: XW] = gx[i];
      gyp[i*YW +: YW] = gy[i];
    end
  end

  ghost_mode_ctrl dut (
    .clock          (clk),
    .reset          (rst),
    .tick           (tick),
    .pellet_eaten   (pel),
    .player_x       (px),
    .player_y       (py),
    .ghost_x        (gxp),
    .ghost_y        (gyp),
    .ghost_mode     (mode),
    .frighten_flash (flash),
    .ghost_eaten    (eaten),
    .score_add      (score),
    .game_over      (go)
  );

  always @(posedge clk) chk_d <= chk_req;

  // Outputs of a checked cycle are visible from the edge that ends it.
  always @(negedge clk) begin
    if (chk_d) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL sb_underflow: output with no expectation");
      end else begin
        cur = sbq.pop_front();
        if ({mode, flash, eaten, score, go} !==
            {cur.mode, cur.fl, cur.eat, cur.sc, cur.go}) begin
          nerr++;
          $display("FAIL %s: got mode=%h fl=%b eat=%b sc=%0d go=%b, want mode=%h fl=%b eat=%b sc=%0d go=%b",
                   cur.nm, mode, flash, eaten, score, go,
                   cur.mode, cur.fl, cur.eat, cur.sc, cur.go);
        end
      end
    end
  end

  task automatic cyc(input logic t, input logic p, input logic r,
                     input bit c, input string nm,
                     input logic [7:0] m, input logic f,
                     input logic [3:0] e, input logic [11:0] s,
                     input logic g);
    exp_t x;
    @(negedge clk);
    tick = t;
    pel = p;
    rst = r;
    chk_req = c;
    if (c) begin
      x.nm = nm;
      x.mode = m;
      x.fl = f;
      x.eat = e;
      x.sc = s;
      x.go = g;
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, "", 8'h00, 1'b0, 4'h0, 12'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, "", 8'h00, 1'b0, 4'h0, 12'd0, 1'b0);
  endtask

  task automatic far();
    gx[0] = XW'(10);  gy[0] = YW'(10);
    gx[1] = XW'(50);  gy[1] = YW'(10);
    gx[2] = XW'(200); gy[2] = YW'(10);
    gx[3] = XW'(300); gy[3] = YW'(200);
  endtask

  task automatic put(input int i, input int x, input int y);
    gx[i] = XW'(x);
    gy[i] = YW'(y);
  endtask

  initial begin
    far();
    cyc(1, 1, 1, 1, "reset_prio", 8'h00, 0, 4'h0, 12'd0, 0);

    cyc(0, 1, 0, 1, "pellet_no_tick", 8'h00, 0, 4'h0, 12'd0, 0);
    idle(3);
    cyc(1, 0, 0, 1, "pend_applied", 8'h55, 0, 4'h0, 12'd0, 0);
    run(237);
    cyc(1, 0, 0, 1, "tick239_noflash", 8'h55, 0, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "tick240_flash", 8'h55, 1, 4'h0, 12'd0, 0);
    run(118);
    cyc(1, 0, 0, 1, "tick359", 8'h55, 1, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "tick360_expire", 8'h00, 0, 4'h0, 12'd0, 0);

    cyc(1, 1, 0, 1, "frighten_all", 8'h55, 0, 4'h0, 12'd0, 0);
    put(0, 100, 100);
    put(2, 105, 97);
    cyc(1, 0, 0, 1, "eat_0_2", 8'h66, 0, 4'b0101, 12'd600, 0);
    cyc(0, 0, 0, 1, "score_pulse_only", 8'h66, 0, 4'h0, 12'd0, 0);
    far();
    put(1, 107, 100);
    cyc(1, 0, 0, 1, "eat_1_third", 8'h6A, 0, 4'b0010, 12'd800, 0);
    far();

    cyc(1, 1, 0, 1, "dead_ignore_pel", 8'h6A, 0, 4'h0, 12'd0, 0);
    run(175);
    cyc(1, 0, 0, 1, "dead_tick180", 8'h6A, 0, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "dead_02_chase", 8'h48, 0, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "dead_1_chase", 8'h40, 0, 4'h0, 12'd0, 0);

    cyc(1, 0, 1, 1, "reset_mid", 8'h00, 0, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "after_reset_tick", 8'h00, 0, 4'h0, 12'd0, 0);

    put(3, 100, 100);
    cyc(1, 1, 0, 1, "pel_and_hit_g3", 8'h95, 0, 4'b1000, 12'd200, 0);
    far();
    put(0, 100, 100);
    put(1, 100, 100);
    put(2, 100, 100);
    cyc(1, 0, 0, 1, "chain_sat_2800", 8'hAA, 0, 4'b0111, 12'd2800, 0);
    far();
    cyc(0, 0, 1, 0, "", 8'h00, 0, 4'h0, 12'd0, 0);
    for (int i = 0; i < 4; i++) put(i, 100, 100);
    cyc(1, 1, 0, 1, "eat_all_3000", 8'hAA, 0, 4'b1111, 12'd3000, 0);

    far();
    cyc(0, 0, 1, 1, "reset_again", 8'h00, 0, 4'h0, 12'd0, 0);
    put(0, 100, 108);
    cyc(1, 0, 0, 1, "dy8_no_hit", 8'h00, 0, 4'h0, 12'd0, 0);
    put(0, 92, 100);
    cyc(1, 0, 0, 1, "dx8_no_hit", 8'h00, 0, 4'h0, 12'd0, 0);
    put(0, 93, 100);
    cyc(1, 0, 0, 1, "dx7_death", 8'h00, 0, 4'h0, 12'd0, 1);
    cyc(1, 1, 0, 1, "frozen_pel_tick", 8'h00, 0, 4'h0, 12'd0, 1);
    cyc(0, 1, 0, 0, "", 8'h00, 0, 4'h0, 12'd0, 0);
    cyc(1, 0, 0, 1, "frozen_tick", 8'h00, 0, 4'h0, 12'd0, 1);
    idle(3);

    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
